// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the MEM stage: control-bit positions,
// the data-memory FSM state type and the default wait budget.
package mem_stage_pkg;

  localparam int M_JUMP     = 3;
  localparam int M_BRANCH   = 2;
  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 0;

  localparam int TIMEOUT_DEFAULT = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the memory (slave).
// Handshake: dmem_req is valid and dmem_ack is ready. A transfer happens in
// any cycle where both are high. The master keeps req, we, addr and wdata
// stable until that cycle, and ack may arrive in the same cycle as req.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage_mem_wb.sv
// MEM/WB pipeline register. A bubble clears the writeback controls and
// holds the other fields; a plain load captures the retiring instruction.
module mem_wb_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic        mem_read_i,
  input  logic [1:0]  wb_i,
  input  logic [31:0] alu_i,
  input  logic [31:0] rdata_i,
  input  logic [4:0]  wn_i,
  output logic [1:0]  wb_o,
  output logic [31:0] rd_o,
  output logic [31:0] alu_o,
  output logic [4:0]  wn_o
);

  logic [1:0]  wb_q;
  logic [31:0] rd_q;
  logic [31:0] alu_q;
  logic [4:0]  wn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q  <= '0;
      rd_q  <= '0;
      alu_q <= '0;
      wn_q  <= '0;
    end else if (bubble_i) begin
      wb_q <= '0;
    end else if (load_i) begin
      wb_q  <= wb_i;
      alu_q <= alu_i;
      wn_q  <= wn_i;
      // Read data only moves on loads so stores and ALU ops leave it intact.
      if (mem_read_i) begin
        rd_q <= rdata_i;
      end
    end
  end

  assign wb_o  = wb_q;
  assign rd_o  = rd_q;
  assign alu_o = alu_q;
  assign wn_o  = wn_q;

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: drives the data-memory bus, stalls on a missing
// acknowledge, raises a sticky bus error after TIMEOUT wait cycles, and
// computes the branch/jump redirect.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  WB_Reg,
  input  logic [3:0]  M_Reg,
  input  logic [31:0] ALU_Reg,
  input  logic [31:0] WD,
  input  logic [31:0] branch_PC_Reg,
  input  logic [31:0] J_Reg,
  input  logic [4:0]  WN_mem,
  mem_stage_if.master dmem,
  output logic        stall,
  output logic        PCSrc,
  output logic [31:0] redirect_pc,
  output logic [1:0]  WB_wb,
  output logic [31:0] RD_wb,
  output logic [31:0] ALU_wb,
  output logic [4:0]  WN_wb,
  output logic        misalign,
  output logic        bus_err,
  output mem_state_e  dbg_state_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  mem_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          misalign_q;
  logic          bus_err_q;
  logic          to_err;

  logic jump, branch, mem_read, mem_write, mem_op, misaligned, req, kill;

  assign jump       = M_Reg[M_JUMP];
  assign branch     = M_Reg[M_BRANCH];
  assign mem_read   = M_Reg[M_MEMREAD];
  assign mem_write  = M_Reg[M_MEMWRITE];
  assign mem_op     = mem_read | mem_write;
  assign misaligned = mem_op & (ALU_Reg[1:0] != 2'b00);

  assign req              = mem_op & ~misaligned & ~bus_err_q;
  assign dmem.dmem_req    = req;
  assign dmem.dmem_we     = mem_write;
  assign dmem.dmem_addr   = ALU_Reg;
  assign dmem.dmem_wdata  = WD;

  assign stall = req & ~dmem.dmem_ack;
  // Ops that never reach the bus still leave the stage, but as bubbles.
  assign kill  = misaligned | (mem_op & bus_err_q);

  assign PCSrc       = jump | (branch & (ALU_Reg == 32'd0));
  assign redirect_pc = jump ? J_Reg : branch_PC_Reg;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_err  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (stall) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (dmem.dmem_ack) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = ST_ERR;
          to_err  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      misalign_q <= misaligned;
      bus_err_q  <= bus_err_q | to_err;
    end
  end

  assign misalign    = misalign_q;
  assign bus_err     = bus_err_q;
  assign dbg_state_o = state_q;

  mem_wb_reg u_mem_wb (
    .clk        (clk),
    .rst        (rst),
    .load_i     (~stall),
    .bubble_i   (stall | kill),
    .mem_read_i (mem_read),
    .wb_i       (WB_Reg),
    .alu_i      (ALU_Reg),
    .rdata_i    (dmem.dmem_rdata),
    .wn_i       (WN_mem),
    .wb_o       (WB_wb),
    .rd_o       (RD_wb),
    .alu_o      (ALU_wb),
    .wn_o       (WN_wb)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a memory responder with programmable
// acknowledge latency and a transaction-level model of the stage's effects.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  WB_Reg;
  logic [3:0]  M_Reg;
  logic [31:0] ALU_Reg, WD, branch_PC_Reg, J_Reg;
  logic [4:0]  WN_mem;
  logic        stall, PCSrc;
  logic [31:0] redirect_pc;
  logic [1:0]  WB_wb;
  logic [31:0] RD_wb, ALU_wb;
  logic [4:0]  WN_wb;
  logic        misalign, bus_err;
  mem_state_e  dbg_state;

  mem_stage_if dmem();

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .WB_Reg        (WB_Reg),
    .M_Reg         (M_Reg),
    .ALU_Reg       (ALU_Reg),
    .WD            (WD),
    .branch_PC_Reg (branch_PC_Reg),
    .J_Reg         (J_Reg),
    .WN_mem        (WN_mem),
    .dmem          (dmem.master),
    .stall         (stall),
    .PCSrc         (PCSrc),
    .redirect_pc   (redirect_pc),
    .WB_wb         (WB_wb),
    .RD_wb         (RD_wb),
    .ALU_wb        (ALU_wb),
    .WN_wb         (WN_wb),
    .misalign      (misalign),
    .bus_err       (bus_err),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory responder ----------------
  logic [31:0] slave_mem [256];
  int          ack_delay;
  int          req_cnt;

  function automatic logic [31:0] init_word(input int i);
    return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      req_cnt <= 0;
      for (int i = 0; i < 256; i++) slave_mem[i] <= init_word(i);
    end else if (dmem.dmem_req && dmem.dmem_ack) begin
      req_cnt <= 0;
      if (dmem.dmem_we) slave_mem[dmem.dmem_addr[9:2]] <= dmem.dmem_wdata;
    end else if (dmem.dmem_req) begin
      req_cnt <= req_cnt + 1;
    end else begin
      req_cnt <= 0;
    end
  end

  assign dmem.dmem_ack   = dmem.dmem_req && (req_cnt >= ack_delay);
  assign dmem.dmem_rdata = slave_mem[dmem.dmem_addr[9:2]];

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [256];
  logic [1:0]  e_wb;
  logic [31:0] e_rd, e_alu;
  logic [4:0]  e_wn;
  logic        e_bus_err;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e_wb = '0; e_rd = '0; e_alu = '0; e_wn = '0; e_bus_err = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".WB_wb"},   32'(WB_wb),   32'(e_wb));
    check({tag, ".RD_wb"},   RD_wb,        e_rd);
    check({tag, ".ALU_wb"},  ALU_wb,       e_alu);
    check({tag, ".WN_wb"},   32'(WN_wb),   32'(e_wn));
    check({tag, ".bus_err"}, 32'(bus_err), 32'(e_bus_err));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    M_Reg = '0; WB_Reg = '0; ALU_Reg = '0; WD = '0; WN_mem = '0;
    branch_PC_Reg = '0; J_Reg = '0; ack_delay = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_regs("reset");
    check("reset.misalign", 32'(misalign), 32'd0);
    check("reset.state", 32'(dbg_state), 32'(ST_IDLE));
    check("reset.req", 32'(dmem.dmem_req), 32'd0);
  endtask

  // Present one instruction, let the responder answer after 'delay' cycles,
  // check every cycle it occupies the stage and the state it leaves behind.
  task automatic run_op(input string tag, input logic [3:0] m, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] wb, input logic [4:0] wn,
                        input int delay);
    logic mem_op, mis, req_e, err_e, killed, pcsrc_e;
    logic [31:0] bpc, jt, rpc_e;
    int n_stall;
    bpc     = $urandom;
    jt      = $urandom;
    mem_op  = m[1] | m[0];
    mis     = mem_op && (a[1:0] != 2'b00);
    req_e   = mem_op && !mis && !e_bus_err;
    err_e   = req_e && (delay > TO);
    n_stall = !req_e ? 0 : (err_e ? TO + 1 : delay);
    pcsrc_e = m[3] || (m[2] && (a == 32'd0));
    rpc_e   = m[3] ? jt : bpc;

    M_Reg = m; ALU_Reg = a; WD = wd; WB_Reg = wb; WN_mem = wn;
    branch_PC_Reg = bpc; J_Reg = jt; ack_delay = delay;
    #1;
    for (int c = 0; c < n_stall; c++) begin
      check({tag, ".stall"}, 32'(stall), 32'd1);
      check({tag, ".req"},   32'(dmem.dmem_req), 32'd1);
      check({tag, ".we"},    32'(dmem.dmem_we), 32'(m[0]));
      check({tag, ".addr"},  dmem.dmem_addr, a);
      check({tag, ".wdata"}, dmem.dmem_wdata, wd);
      if (c > 0) begin
        check({tag, ".wb_bubble"}, 32'(WB_wb), 32'd0);
        check({tag, ".alu_hold"},  ALU_wb, e_alu);
        check({tag, ".state_wait"}, 32'(dbg_state), 32'(ST_WAIT));
      end
      @(posedge clk); #1;
    end
    if (err_e) begin
      e_bus_err = 1'b1;
      check({tag, ".state_err"}, 32'(dbg_state), 32'(ST_ERR));
    end
    check({tag, ".bus_err_now"}, 32'(bus_err), 32'(e_bus_err));
    check({tag, ".stall_off"},   32'(stall), 32'd0);
    check({tag, ".req_final"},   32'(dmem.dmem_req), 32'(req_e && !err_e));
    check({tag, ".pcsrc"},       32'(PCSrc), 32'(pcsrc_e));
    check({tag, ".redirect"},    redirect_pc, rpc_e);

    killed = mis || (mem_op && e_bus_err);
    if (killed) begin
      e_wb = '0;
    end else begin
      e_wb = wb; e_alu = a; e_wn = wn;
      if (m[1]) e_rd = ref_mem[a[9:2]];
      if (m[0]) ref_mem[a[9:2]] = wd;
    end
    @(posedge clk); #1;
    check({tag, ".misalign"}, 32'(misalign), 32'(mis));
    check_regs(tag);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [3:0]  m;
    logic [31:0] a;
    int          kind;
    rst = 1'b1;
    set_idle();
    model_reset();
    @(posedge clk); #1;
    do_reset();

    run_op("load_ack0",  4'b0010, 32'h10, 32'h0, 2'b11, 5'd7, 0);
    run_op("store_ack3", 4'b0001, 32'h20, 32'hDEAD_BEEF, 2'b01, 5'd3, 3);
    run_op("load_back",  4'b0010, 32'h20, 32'h0, 2'b10, 5'd9, 1);
    run_op("misalign",   4'b0010, 32'h13, 32'h0, 2'b11, 5'd4, 0);
    run_op("after_mis",  4'b0000, 32'h1234, 32'h0, 2'b01, 5'd5, 0);
    run_op("br_taken",   4'b0100, 32'h0, 32'h0, 2'b00, 5'd0, 0);
    run_op("br_not",     4'b0100, 32'h8, 32'h0, 2'b00, 5'd0, 0);
    run_op("jump_br",    4'b1100, 32'h5, 32'h0, 2'b10, 5'd31, 0);
    run_op("load_to_max", 4'b0010, 32'h30, 32'h0, 2'b11, 5'd12, TO);

    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 5);
      a    = 32'($urandom_range(0, 255)) << 2;
      case (kind)
        0: begin m = 4'b0000; a = $urandom; end
        1: m = 4'b0010;
        2: m = 4'b0001;
        3: begin
             m = ($urandom_range(0, 1) == 1) ? 4'b0010 : 4'b0001;
             a = a | 32'($urandom_range(1, 3));
           end
        4: begin m = 4'b0100; if ($urandom_range(0, 1) == 1) a = 32'd0; end
        default: m = ($urandom_range(0, 1) == 1) ? 4'b1000 : 4'b1100;
      endcase
      run_op("rand", m, a, $urandom, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
             $urandom_range(0, 4));
    end

    run_op("timeout",     4'b0010, 32'h44, 32'h0, 2'b11, 5'd6, 1000);
    run_op("err_load",    4'b0010, 32'h48, 32'h0, 2'b11, 5'd8, 0);
    run_op("err_store",   4'b0001, 32'h4C, 32'h1111_2222, 2'b01, 5'd2, 0);
    run_op("err_alu",     4'b0000, 32'h77, 32'h0, 2'b10, 5'd10, 0);
    do_reset();
    run_op("post_err",    4'b0010, 32'h48, 32'h0, 2'b11, 5'd8, 0);

    // Reset while the stage sits in its second wait cycle.
    M_Reg = 4'b0010; ALU_Reg = 32'h40; WB_Reg = 2'b11; WN_mem = 5'd13; ack_delay = 10;
    #1;
    check("rstwait.stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    check("rstwait.w1", 32'(dbg_state), 32'(ST_WAIT));
    @(posedge clk); #1;
    check("rstwait.w2", 32'(dbg_state), 32'(ST_WAIT));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_regs("rstwait");
    check("rstwait.misalign", 32'(misalign), 32'd0);
    check("rstwait.state", 32'(dbg_state), 32'(ST_IDLE));
    check("rstwait.req", 32'(dmem.dmem_req), 32'd1);
    run_op("fresh", 4'b0010, 32'h40, 32'h0, 2'b11, 5'd13, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1);
  end

endmodule
